// File: rtl/recirculacion_param.sv
// rtl/recirculacion_param.sv - parametrised registered lane splitter between L1 and the probador
//
// Steers NUM_CH lanes of data/valid to L1 or back to the probador. The
// committed route (route_l1) follows IDL only on an all-lanes-idle cycle,
// so a burst is never split between destinations. While routed to L1, a
// cycle with L1_pause high sends that cycle's words to the probador instead.
// Two saturating counters track the valid words delivered on each path.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   IDL             requested route (1 = L1, 0 = probador)
//   data_in         lane words, lane i at [i*DATA_W +: DATA_W]
//   valid_in        per-lane valid
//   L1_pause        L1 cannot accept this cycle
//   clr_cnt         synchronous clear of both counters
//   L1_data/valid   registered lane words to L1
//   probador_data/valid  registered lane words to the probador
//   route_l1        committed route, 1 = L1
//   l1_count        valid words delivered to L1 (saturating)
//   recirc_count    valid words delivered to the probador (saturating)

module recirculacion_param #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     IDL,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        valid_in,
    input  logic                     L1_pause,
    input  logic                     clr_cnt,
    output logic [NUM_CH*DATA_W-1:0] L1_data,
    output logic [NUM_CH-1:0]        L1_valid,
    output logic [NUM_CH*DATA_W-1:0] probador_data,
    output logic [NUM_CH-1:0]        probador_valid,
    output logic                     route_l1,
    output logic [CNT_W-1:0]         l1_count,
    output logic [CNT_W-1:0]         recirc_count
);

    typedef enum logic {
        ST_RECIRC = 1'b0,
        ST_L1     = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             lanes_idle;
    logic             sel_l1;
    logic [CNT_W:0]   pop;
    logic [CNT_W:0]   l1_sum;
    logic [CNT_W:0]   recirc_sum;

    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    assign lanes_idle = (valid_in == '0);

    // Steering uses the pre-edge state; pause only matters while in L1.
    assign sel_l1 = (state_q == ST_L1) && !L1_pause;

    always_comb begin
        state_d = state_q;
        // A pending request only commits at an all-idle cycle; if IDL reverts
        // before the gap the request simply disappears.
        if ((IDL != state_q) && lanes_idle) begin
            state_d = IDL ? ST_L1 : ST_RECIRC;
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + {{CNT_W{1'b0}}, valid_in[i]};
        end
    end

    // One extra bit of headroom so the saturation compare sees any overflow.
    assign l1_sum     = {1'b0, l1_count} + pop;
    assign recirc_sum = {1'b0, recirc_count} + pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RECIRC;
        end else begin
            state_q <= state_d;
        end
    end

    assign route_l1 = (state_q == ST_L1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            L1_data        <= '0;
            L1_valid       <= '0;
            probador_data  <= '0;
            probador_valid <= '0;
        end else if (sel_l1) begin
            L1_data        <= data_in;
            L1_valid       <= valid_in;
            probador_data  <= '0;
            probador_valid <= '0;
        end else begin
            L1_data        <= '0;
            L1_valid       <= '0;
            probador_data  <= data_in;
            probador_valid <= valid_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l1_count     <= '0;
            recirc_count <= '0;
        end else if (clr_cnt) begin
            // Clear wins; this cycle's words are deliberately not counted.
            l1_count     <= '0;
            recirc_count <= '0;
        end else if (sel_l1) begin
            if (l1_sum > CNT_MAX) begin
                l1_count <= '1;
            end else begin
                l1_count <= l1_sum[CNT_W-1:0];
            end
        end else begin
            if (recirc_sum > CNT_MAX) begin
                recirc_count <= '1;
            end else begin
                recirc_count <= recirc_sum[CNT_W-1:0];
            end
        end
    end

endmodule
